// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the execute-stage controller
// (master) and the multi-cycle ALU (slave).
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  result, zero, hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, zero, hi, lo, busy, done
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Ops 0-11 complete in one cycle. MULT/MULTU and
// DIV/DIVU iterate WIDTH cycles on operand magnitudes, then spend one cycle
// on sign fixup before writing the HI/LO pair.
// Define ALU_MC_DIV_EN to build the divider. Without it, ops 14/15 behave as
// a single-cycle NOP (result = a).
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rstn,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [SHW-1:0]   count;
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_nxt;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             is_multi;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   msum;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0] fix_hi, fix_lo;
`ifdef ALU_MC_DIV_EN
    logic             is_div;
    logic             neg_r;
    logic [WIDTH-1:0] a_sav;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo, rem;
`endif

`ifdef ALU_MC_DIV_EN
    assign is_multi = (bus.op[3:2] == 2'b11);
`else
    assign is_multi = (bus.op[3:1] == 3'b110);
`endif

    assign accept = bus.start && (state == IDLE);
    assign shamt  = bus.a[SHW-1:0];

    // Single-cycle result for ops 0-11; anything else falls back to NOP.
    always_comb begin
        alu_res = bus.a;
        case (bus.op)
            4'd1:  alu_res = bus.a + bus.b;
            4'd2:  alu_res = bus.a - bus.b;
            4'd3:  alu_res = bus.a & bus.b;
            4'd4:  alu_res = bus.a | bus.b;
            4'd5:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd6:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            4'd7:  alu_res = bus.b << shamt;
            4'd8:  alu_res = bus.b >> shamt;
            4'd9:  alu_res = ~(bus.a | bus.b);
            4'd10: alu_res = $unsigned($signed(bus.b) >>> shamt);
            4'd11: alu_res = bus.a ^ bus.b;
            default: alu_res = bus.a;
        endcase
    end

    // Operand magnitudes taken at launch; op[0]=0 selects the signed variants.
    always_comb begin
        a_neg = !bus.op[0] && bus.a[WIDTH-1];
        b_neg = !bus.op[0] && bus.b[WIDTH-1];
        mag_a = a_neg ? (WIDTH'(0) - bus.a) : bus.a;
        mag_b = b_neg ? (WIDTH'(0) - bus.b) : bus.b;
    end

    // One iteration: shift-add multiply, or restoring divide step.
    always_comb begin
        msum    = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, dvsr} : {(WIDTH+1){1'b0}});
        acc_nxt = {1'b0, msum, acc[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr};
        if (is_div) begin
            if (!trial[WIDTH])
                acc_nxt = {trial, acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc[2*WIDTH-1:0], 1'b0};
        end
`endif
    end

    // Sign fixup and special cases applied in FIX.
    always_comb begin
        prod     = acc[2*WIDTH-1:0];
        prod_neg = (2*WIDTH)'(0) - prod;
        fix_hi   = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        fix_lo   = neg_q ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
`ifdef ALU_MC_DIV_EN
        quo = acc[WIDTH-1:0];
        rem = acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            if (dvsr == '0) begin
                fix_lo = '1;
                fix_hi = a_sav;
            end else begin
                fix_lo = neg_q ? (WIDTH'(0) - quo) : quo;
                fix_hi = neg_r ? (WIDTH'(0) - rem) : rem;
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: only IDLE accepts work, so starts during RUN/FIX drop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_multi) state_nxt = RUN;
            RUN:     if (count == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: busy covers the WIDTH iteration cycles.
    always_comb begin
        bus.busy = (state == RUN);
    end

    // Datapath and registered outputs; reset aborts without touching HI/LO later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.result <= '0;
            bus.zero   <= 1'b1;
            bus.hi     <= '0;
            bus.lo     <= '0;
            bus.done   <= 1'b0;
            count      <= '0;
            acc        <= '0;
            dvsr       <= '0;
            neg_q      <= 1'b0;
`ifdef ALU_MC_DIV_EN
            is_div     <= 1'b0;
            neg_r      <= 1'b0;
            a_sav      <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !is_multi) begin
                        bus.result <= alu_res;
                        bus.zero   <= (alu_res == '0);
                        bus.done   <= 1'b1;
                    end else if (accept) begin
                        count <= SHW'(WIDTH - 1);
                        neg_q <= a_neg ^ b_neg;
                        acc   <= {{(WIDTH+1){1'b0}}, mag_b};
                        dvsr  <= mag_a;
`ifdef ALU_MC_DIV_EN
                        is_div <= bus.op[1];
                        neg_r  <= a_neg;
                        a_sav  <= bus.a;
                        if (bus.op[1]) begin
                            acc  <= {{(WIDTH+1){1'b0}}, mag_a};
                            dvsr <= mag_b;
                        end
`endif
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (count != '0)
                        count <= count - 1'b1;
                end
                FIX: begin
                    bus.hi     <= fix_hi;
                    bus.lo     <= fix_lo;
                    bus.result <= fix_lo;
                    bus.zero   <= (fix_lo == '0);
                    bus.done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with hand-computed expectations for alu_mc.
// The divider checks follow whichever way ALU_MC_DIV_EN is set.
module tb_alu_mc;
    logic clk;
    logic rstn;
    int   checkCount;
    int   passCount;
    int   lat;
    int   busyCnt;

    alu_mc_if #(.WIDTH(32)) bus ();

    alu_mc #(.WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Present one request for a single edge, then sample 1ns after that edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until done, optionally disturbing inputs while busy.
    task automatic waitDone(input bit inject, output int latency, output int busyCycles);
        latency    = 0;
        busyCycles = 0;
        while (!bus.done && latency < 200) begin
            if (bus.busy) busyCycles++;
            if (inject && latency == 3) begin
                bus.a = 32'hDEADBEEF;
                bus.b = 32'h0BADF00D;
            end
            if (inject && latency == 5) begin
                bus.start = 1'b1;
                bus.op    = 4'd1;
                bus.a     = 32'd1;
                bus.b     = 32'd1;
            end
            if (inject && latency == 6) bus.start = 1'b0;
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs[13];

    initial begin
        checkCount = 0;
        passCount  = 0;
        rstn       = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 4'd0;
        bus.a      = '0;
        bus.b      = '0;

        vecs[0]  = '{4'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, "add_wrap"};
        vecs[1]  = '{4'd2,  32'd5,        32'd5,        32'h00000000, "sub_zero"};
        vecs[2]  = '{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and"};
        vecs[3]  = '{4'd4,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, "or"};
        vecs[4]  = '{4'd5,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, "slt_pos_neg"};
        vecs[5]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt_neg_pos"};
        vecs[6]  = '{4'd6,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, "sltu"};
        vecs[7]  = '{4'd7,  32'd35,       32'h00000001, 32'h00000008, "sll_amt35"};
        vecs[8]  = '{4'd8,  32'd4,        32'hF0000000, 32'h0F000000, "srl"};
        vecs[9]  = '{4'd9,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, "nor"};
        vecs[10] = '{4'd10, 32'd4,        32'hF0000000, 32'hFF000000, "sra"};
        vecs[11] = '{4'd11, 32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, "xor"};
        vecs[12] = '{4'd0,  32'h12345678, 32'h00000009, 32'h12345678, "nop"};

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_result", 64'(bus.result), 64'h0);
        checkOutput("rst_zero",   64'(bus.zero),   64'h1);
        checkOutput("rst_hi",     64'(bus.hi),     64'h0);
        checkOutput("rst_lo",     64'(bus.lo),     64'h0);
        checkOutput("rst_busy",   64'(bus.busy),   64'h0);
        checkOutput("rst_done",   64'(bus.done),   64'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Single-cycle ops issued back to back, one per cycle.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput({vecs[i].tag, "_result"}, 64'(bus.result), 64'(vecs[i].exp));
            checkOutput({vecs[i].tag, "_zero"},   64'(bus.zero),   64'(vecs[i].exp == 32'h0));
            checkOutput({vecs[i].tag, "_done"},   64'(bus.done),   64'h1);
            checkOutput({vecs[i].tag, "_busy"},   64'(bus.busy),   64'h0);
        end
        checkOutput("single_hi_kept", 64'(bus.hi), 64'h0);
        checkOutput("single_lo_kept", 64'(bus.lo), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("done_pulse_drop", 64'(bus.done), 64'h0);
        checkOutput("result_hold",     64'(bus.result), 64'h12345678);

        // MULT -3 * 7 with a dropped start and operand changes while busy.
        applyStimulus(4'd12, 32'hFFFFFFFD, 32'd7);
        checkOutput("mult_busy_e0", 64'(bus.busy), 64'h1);
        waitDone(1'b1, lat, busyCnt);
        checkOutput("mult_latency", 64'(lat), 64'd33);
        checkOutput("mult_busycnt", 64'(busyCnt), 64'd32);
        checkOutput("mult_hilo",    {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
        checkOutput("mult_result",  64'(bus.result), 64'hFFFFFFEB);
        checkOutput("mult_busy_end", 64'(bus.busy), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("mult_done_pulse", 64'(bus.done), 64'h0);
        checkOutput("mult_no_queued",  64'(bus.busy), 64'h0);

        // MULTU 0xFFFFFFFF * 2, then a single op must leave HI/LO alone.
        applyStimulus(4'd13, 32'hFFFFFFFF, 32'd2);
        waitDone(1'b0, lat, busyCnt);
        checkOutput("multu_latency", 64'(lat), 64'd33);
        checkOutput("multu_hilo", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);
        applyStimulus(4'd1, 32'd10, 32'd20);
        checkOutput("b2b_add_result", 64'(bus.result), 64'd30);
        checkOutput("b2b_add_hilo", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);

`ifdef ALU_MC_DIV_EN
        applyStimulus(4'd14, 32'hFFFFFFF9, 32'd2);
        waitDone(1'b0, lat, busyCnt);
        checkOutput("div_latency", 64'(lat), 64'd33);
        checkOutput("div_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
        applyStimulus(4'd15, 32'd9, 32'd0);
        waitDone(1'b0, lat, busyCnt);
        checkOutput("divu0_latency", 64'(lat), 64'd33);
        checkOutput("divu0_hilo", {bus.hi, bus.lo}, 64'h00000009_FFFFFFFF);
        applyStimulus(4'd14, 32'h80000000, 32'hFFFFFFFF);
        waitDone(1'b0, lat, busyCnt);
        checkOutput("div_ovf_hilo", {bus.hi, bus.lo}, 64'h00000000_80000000);
        checkOutput("div_ovf_result", 64'(bus.result), 64'h80000000);
`else
        applyStimulus(4'd14, 32'd9, 32'd3);
        checkOutput("div_off_result", 64'(bus.result), 64'd9);
        checkOutput("div_off_done",   64'(bus.done),   64'h1);
        checkOutput("div_off_busy",   64'(bus.busy),   64'h0);
        checkOutput("div_off_hilo", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);
        applyStimulus(4'd15, 32'd7, 32'd0);
        checkOutput("divu_off_result", 64'(bus.result), 64'd7);
        checkOutput("divu_off_busy",   64'(bus.busy),   64'h0);
`endif

        // Asynchronous reset in the middle of a MULT.
        applyStimulus(4'd12, 32'd5, 32'd6);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_rst_busy", 64'(bus.busy), 64'h1);
        rstn = 1'b0;
        #1;
        checkOutput("midrst_result", 64'(bus.result), 64'h0);
        checkOutput("midrst_zero",   64'(bus.zero),   64'h1);
        checkOutput("midrst_hilo",   {bus.hi, bus.lo}, 64'h0);
        checkOutput("midrst_busy",   64'(bus.busy),   64'h0);
        checkOutput("midrst_done",   64'(bus.done),   64'h0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(4'd1, 32'd2, 32'd3);
        checkOutput("post_rst_add",  64'(bus.result), 64'd5);
        checkOutput("post_rst_done", 64'(bus.done),   64'h1);
        checkOutput("post_rst_hilo", {bus.hi, bus.lo}, 64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
